// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames
// and assembles 3-byte movement packets into per-packet X/Y deltas and buttons.
module ps2_mouse_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  logic          clk_s1, clk_s2, clk_hist;
  logic          dat_s1, dat_s2;
  logic          fall;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [1:0]    byte_idx;
  logic [7:0]    b0, b1;
  logic [TW-1:0] tcnt;

  // Two-flop synchronizers plus clock history; idle-high lines reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_hist & ~clk_s2;

  // Frame FSM, packet assembly and inactivity timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RX_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      par          <= 1'b0;
      byte_idx     <= 2'd0;
      b0           <= 8'd0;
      b1           <= 8'd0;
      tcnt         <= '0;
      xm           <= 9'd0;
      ym           <= 9'd0;
      buttons      <= 3'd0;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
      xm           <= 9'd0;
      ym           <= 9'd0;
      if (fall) begin
        // An edge always wins over a simultaneous timeout.
        tcnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_s2) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= dat_s2;
            state <= RX_STOP;
          end
          default: begin
            state <= RX_IDLE;
            if (dat_s2 && ((^shreg) ^ par)) begin
              case (byte_idx)
                2'd0: begin
                  // Header bytes always carry bit 3 set; anything else is a resync drop.
                  if (shreg[3]) begin
                    b0       <= shreg;
                    byte_idx <= 2'd1;
                  end
                end
                2'd1: begin
                  b1       <= shreg;
                  byte_idx <= 2'd2;
                end
                default: begin
                  byte_idx     <= 2'd0;
                  packet_valid <= 1'b1;
                  buttons      <= b0[2:0];
                  xm           <= b0[6] ? 9'd0 : {b0[4], b1};
                  ym           <= b0[7] ? 9'd0 : {b0[5], shreg};
                end
              endcase
            end else begin
              frame_error <= 1'b1;
              byte_idx    <= 2'd0;
            end
          end
        endcase
      end else if (state == RX_IDLE && byte_idx == 2'd0) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt        <= '0;
        state       <= RX_IDLE;
        byte_idx    <= 2'd0;
        frame_error <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: fixed packet table, hand-built error/timeout/reset
// sequences and randomized traffic checked against a byte-level packet model.
module tb_ps2_mouse_rx;

  localparam int unsigned TO   = 2000;
  localparam int          HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] xm, ym;
  logic [2:0] buttons;
  logic       packet_valid, frame_error;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .xm(xm), .ym(ym), .buttons(buttons),
    .packet_valid(packet_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } pkt_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] xm, ym;
    logic [2:0] btn;
  } vec_t;

  int   tests = 0;
  int   failed = 0;
  pkt_t obs_q[$];
  pkt_t mdl_q[$];
  int   err_seen = 0;
  int   zero_viol = 0;

  // Reference model state: packet position and captured header/X bytes.
  int         m_idx = 0;
  int         m_err = 0;
  logic [7:0] m_b0, m_b1;
  logic [2:0] m_btn = 3'd0;

  always @(negedge clk) begin
    if (!reset) begin
      if (packet_valid) obs_q.push_back('{xm, ym, buttons});
      else if (xm != 9'd0 || ym != 9'd0) zero_viol++;
      if (frame_error) err_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] axis(input logic sgn, input logic ovf, input logic [7:0] mag);
    int v;
    if (ovf) return 9'd0;
    v = sgn ? int'(mag) - 256 : int'(mag);
    return 9'(v);
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++;
      m_idx = 0;
    end else if (m_idx == 0) begin
      if (b[3]) begin m_b0 = b; m_idx = 1; end
    end else if (m_idx == 1) begin
      m_b1 = b;
      m_idx = 2;
    end else begin
      m_btn = m_b0[2:0];
      mdl_q.push_back('{axis(m_b0[4], m_b0[6], m_b1), axis(m_b0[5], m_b0[7], b), m_btn});
      m_idx = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 0, 0);
    send_byte(b1, 0, 0);
    send_byte(b2, 0, 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_scn(input string name);
    int n;
    check({name, "_npkt"}, 32'(obs_q.size()), 32'(mdl_q.size()));
    n = (obs_q.size() < mdl_q.size()) ? obs_q.size() : mdl_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_xm"},  32'(obs_q[i].xm),  32'(mdl_q[i].xm));
      check({name, "_ym"},  32'(obs_q[i].ym),  32'(mdl_q[i].ym));
      check({name, "_btn"}, 32'(obs_q[i].btn), 32'(mdl_q[i].btn));
    end
    check({name, "_err"}, 32'(err_seen), 32'(m_err));
    check({name, "_zero"}, 32'(zero_viol), 32'd0);
    check({name, "_hold"}, 32'(buttons), 32'(m_btn));
    obs_q.delete();
    mdl_q.delete();
    err_seen  = 0;
    m_err     = 0;
    zero_viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_idx = 0;
    m_btn = 3'd0;
    obs_q.delete();
    mdl_q.delete();
    err_seen = 0;
    m_err    = 0;
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] b0, b1, b2;
    int         r;

    vecs[0] = '{8'h08, 8'h05, 8'hFB, 9'h005, 9'h0FB, 3'b000};
    vecs[1] = '{8'h39, 8'hF6, 8'h02, 9'h1F6, 9'h102, 3'b001};
    vecs[2] = '{8'h48, 8'h80, 8'h10, 9'h000, 9'h010, 3'b000};
    vecs[3] = '{8'hAF, 8'h7F, 8'h80, 9'h07F, 9'h000, 3'b111};
    vecs[4] = '{8'h1E, 8'h00, 8'hFF, 9'h100, 9'h0FF, 3'b110};

    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_xm", 32'(xm), 32'd0);
    check("rst_ym", 32'(ym), 32'd0);
    check("rst_btn", 32'(buttons), 32'd0);
    check("rst_pv", 32'(packet_valid), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    do_reset();

    // Fixed packet table with constant expectations.
    for (int i = 0; i < 5; i++) begin
      send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check("tbl_npkt", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) begin
        check("tbl_xm",  32'(obs_q[0].xm),  32'(vecs[i].xm));
        check("tbl_ym",  32'(obs_q[0].ym),  32'(vecs[i].ym));
        check("tbl_btn", 32'(obs_q[0].btn), 32'(vecs[i].btn));
      end
      check_scn("tbl");
    end

    // Bad parity, then bad stop bit, each followed by a good packet.
    send_byte(8'h08, 1, 0);
    send_packet(8'h08, 8'h01, 8'h02);
    check_scn("badpar");
    send_byte(8'h09, 0, 1);
    send_packet(8'h09, 8'h03, 8'h04);
    check_scn("badstop");

    // Header without bit 3 is dropped silently.
    send_byte(8'h00, 0, 0);
    send_packet(8'h08, 8'h01, 8'h01);
    if (obs_q.size() > 0) begin
      check("resync_xm", 32'(obs_q[0].xm), 32'h001);
      check("resync_ym", 32'(obs_q[0].ym), 32'h001);
    end
    check_scn("resync");

    // Partial packet then silence: one timeout error, then normal decode.
    send_byte(8'h08, 0, 0);
    send_byte(8'h05, 0, 0);
    repeat (TO + 50) @(negedge clk);
    m_err++;
    m_idx = 0;
    check_scn("timeout");
    send_packet(8'h0A, 8'h07, 8'h09);
    check_scn("post_to");

    // Reset after 5 bits of a frame discards it.
    send_bits(11'b110_0000_1000 << 1, 5);
    do_reset();
    send_packet(8'h08, 8'h05, 8'hFB);
    check_scn("rst_mid");

    // Randomized traffic against the model.
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) send_byte(8'($urandom) & 8'hF7, 0, 0);
      else if (r == 1) send_byte(8'($urandom), 1, 0);
      else if (r == 2) send_byte(8'($urandom), 0, 1);
      b0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 5) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_packet(b0, b1, b2);
      check_scn("rnd");
    end
    repeat (TO + 100) @(negedge clk);
    if (m_idx != 0) begin
      m_err++;
      m_idx = 0;
    end
    check_scn("drain");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
